// File: rtl/mem_pkg.sv
// Shared types and helpers for the main memory and the data cache above it.
// Words move between the two as four bytes, big-endian: byte 0 is bits 31:24.
package mem_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_bytes_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Byte 0 lands in the most significant position.
  function automatic logic [31:0] pack_word(input word_bytes_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic word_bytes_t unpack_word(input logic [31:0] w);
    word_bytes_t b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag, used to time fixed-latency slaves.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset (count -> 0)
//   load        - load load_value this edge (takes priority over dec)
//   load_value  - value to load
//   dec         - decrement this edge; holds at zero rather than wrapping
//   zero        - count is currently zero
module mem_latency_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/main_memory.sv
// Word-addressed, byte-organised backing memory behind the data cache.
// One access at a time with a fixed LATENCY from acceptance to completion.
//
// Handshake: a request (mem_req, with address/write_en/mem_data_in) is taken
// on any rising edge where the FSM is IDLE; the inputs are latched then and
// ignored afterwards. mem_busy is high from the accepting edge until the
// completing edge. mem_done pulses for one cycle after the completing edge,
// when read data is valid on mem_data_out. The FSM is already IDLE during
// the mem_done cycle, so a new request there is taken with no gap. Requests
// while busy are dropped, not queued.
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   mem_req       - access request (sampled only in IDLE)
//   address       - byte address; bits 1:0 and bits above the storage size ignored
//   write_en      - 1 = write word, 0 = read word
//   mem_data_in   - write bytes, [0] = MSB
//   mem_data_out  - last read result, [0] = MSB
//   mem_busy      - access in flight
//   mem_done      - one-cycle completion pulse
module main_memory
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned LATENCY   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [31:0] address,
  input  logic        write_en,
  input  word_bytes_t mem_data_in,
  output word_bytes_t mem_data_out,
  output logic        mem_busy,
  output logic        mem_done
);

  localparam int unsigned AW  = $clog2(MEM_BYTES);
  localparam int unsigned WAW = AW - 2;
  localparam int unsigned CW  = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  mem_state_t        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [WAW-1:0]    widx_q, widx_d;
  word_bytes_t       wdata_q, wdata_d;
  word_bytes_t       rdata_q, rdata_d;

  // Storage is deliberately never reset.
  byte_t             mem_q [MEM_BYTES];
  logic              mem_we;

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  // Address bits outside the word index have no meaning here.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{address[31:AW], address[1:0]};

  mem_latency_counter #(
    .WIDTH (CW)
  ) u_latency (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (LOAD_VAL),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = we_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          we_d     = write_en;
          widx_d   = address[AW-1:2];
          wdata_d  = mem_data_in;
          cnt_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              rdata_d[k] = mem_q[{widx_q, 2'(k)}];
            end
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset on the completing edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        mem_q[{widx_q, 2'(k)}] <= wdata_q[k];
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_busy     = busy_q;
  assign mem_done     = done_q;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build (LATENCY = 5)
  logic        mem_req;
  logic [31:0] address;
  logic        write_en;
  word_bytes_t mem_data_in;
  word_bytes_t mem_data_out;
  logic        mem_busy;
  logic        mem_done;

  // LATENCY = 1 build
  logic        l1_req;
  logic [31:0] l1_address;
  logic        l1_write_en;
  word_bytes_t l1_data_in;
  word_bytes_t l1_data_out;
  logic        l1_busy;
  logic        l1_done;

  main_memory #(.MEM_BYTES(65536), .LATENCY(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .address      (address),
    .write_en     (write_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_busy     (mem_busy),
    .mem_done     (mem_done)
  );

  main_memory #(.MEM_BYTES(65536), .LATENCY(1)) dut_l1 (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (l1_req),
    .address      (l1_address),
    .write_en     (l1_write_en),
    .mem_data_in  (l1_data_in),
    .mem_data_out (l1_data_out),
    .mem_busy     (l1_busy),
    .mem_done     (l1_done)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one access on the selected build (0 = LATENCY 5, 1 = LATENCY 1),
  // measure edges to mem_done and busy cycles, and return the read word.
  task automatic access(input int sel, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, output int lat,
                        output int busy_cycles, output logic [31:0] rword);
    @(negedge clk);
    if (sel == 0) begin
      mem_req = 1'b1; address = addr; write_en = we; mem_data_in = unpack_word(wdata);
    end else begin
      l1_req = 1'b1; l1_address = addr; l1_write_en = we; l1_data_in = unpack_word(wdata);
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
    l1_req  = 1'b0;
    lat = 0;
    busy_cycles = ((sel == 0) ? mem_busy : l1_busy) ? 1 : 0;
    while (!((sel == 0) ? mem_done : l1_done) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if ((sel == 0) ? mem_busy : l1_busy) busy_cycles++;
    end
    rword = pack_word((sel == 0) ? mem_data_out : l1_data_out);
  endtask

  task automatic read_word(input int sel, input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_word, input int exp_lat);
    int lat, bc;
    logic [31:0] r;
    exp_q.push_back(exp_word);
    access(sel, addr, 1'b0, 32'h0, lat, bc, r);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, r, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bc, pulses;
    logic [31:0] r;

    reset = 1'b1;
    mem_req = 1'b0; address = '0; write_en = 1'b0; mem_data_in = '0;
    l1_req = 1'b0; l1_address = '0; l1_write_en = 1'b0; l1_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", mem_busy, 0);
    check("rst_done", mem_done, 0);
    check("rst_data", pack_word(mem_data_out), 32'h0);
    check("rst_l1_data", pack_word(l1_data_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Write DEADBEEF to 0x10: done at k+5, busy for 5 cycles, done one cycle wide.
    access(0, 32'h0000_0010, 1'b1, 32'hDEADBEEF, lat, bc, r);
    check("wr10_lat", lat, 5);
    check("wr10_busy_cycles", bc, 5);
    check("wr10_data_out_unchanged", r, 32'h0);
    @(posedge clk); #1;
    check("wr10_done_width", mem_done, 0);

    read_word(0, "rd10", 32'h0000_0010, 32'hDEADBEEF, 5);
    read_word(0, "rd13", 32'h0000_0013, 32'hDEADBEEF, 5);
    read_word(0, "rd_wrap", 32'h0001_0010, 32'hDEADBEEF, 5);

    // Baselines for later tests.
    access(0, 32'h0000_0020, 1'b1, 32'h55667788, lat, bc, r);
    access(0, 32'h0000_0030, 1'b1, 32'h01020304, lat, bc, r);

    // Request with a different address held high while busy is ignored.
    @(negedge clk);
    mem_req = 1'b1; address = 32'h0000_0010; write_en = 1'b0;
    @(posedge clk); #1;
    address = 32'h0000_0030; write_en = 1'b1; mem_data_in = unpack_word(32'h99999999);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) mem_req = 1'b0;
      if (mem_done) pulses++;
      if (mem_done) check("busy_req_data", pack_word(mem_data_out), 32'hDEADBEEF);
    end
    check("busy_req_done_count", pulses, 1);
    read_word(0, "rd30_untouched", 32'h0000_0030, 32'h01020304, 5);

    // Back-to-back: read request issued in the mem_done cycle of a write.
    access(0, 32'h0000_0040, 1'b1, 32'hA1B2C3D4, lat, bc, r);
    check("b2b_wr_lat", lat, 5);
    check("b2b_wr_keeps_rdata", r, 32'h01020304);
    mem_req = 1'b1; address = 32'h0000_0040; write_en = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b0;
    check("b2b_accepted_busy", mem_busy, 1);
    lat = 0;
    while (!mem_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_rd_lat", lat, 5);
    check("b2b_rd_data", pack_word(mem_data_out), 32'hA1B2C3D4);

    // Reset mid-write aborts it.
    @(negedge clk);
    mem_req = 1'b1; address = 32'h0000_0020; write_en = 1'b1;
    mem_data_in = unpack_word(32'h11223344);
    @(posedge clk); #1;
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", mem_busy, 0);
    check("abort_done", mem_done, 0);
    check("abort_data", pack_word(mem_data_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    read_word(0, "rd20_after_abort", 32'h0000_0020, 32'h55667788, 5);

    // Reset wins over a request on the same edge.
    @(negedge clk);
    reset = 1'b1; mem_req = 1'b1; address = 32'h0000_0010; write_en = 1'b0;
    @(posedge clk); #1;
    check("rst_vs_req_busy", mem_busy, 0);
    @(negedge clk);
    reset = 1'b0; mem_req = 1'b0;

    // LATENCY = 1 build.
    access(1, 32'h0000_0040, 1'b1, 32'hCAFEF00D, lat, bc, r);
    check("l1_wr_lat", lat, 1);
    check("l1_wr_busy_cycles", bc, 1);
    read_word(1, "l1_rd40", 32'h0000_0040, 32'hCAFEF00D, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
